dma_desc_sched: RTL and testbench
=================================

# dma_desc_sched

Descriptor scheduler in front of `dma_transfer`. It accepts transfer descriptors (address, byte length, direction) from a CPU-side register block into a small FIFO and issues them one at a time. It holds each descriptor's configuration stable for the whole transfer and reports per-descriptor completion. It sits between the DMA register file and the `addr`/`length`/`readNotWrite`/`start`/`ready` port of `dma_transfer`.

## Interface
Parameters:
- `AXI_ADDR_W`, `` `AXI_ADDR_W ``: descriptor address width.
- `LEN_W`, 16: descriptor byte-length width; must match `dma_transfer`.
- `DEPTH_LOG2`, 2: FIFO depth = 2^DEPTH_LOG2 entries (default 4).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `push_valid`  in  1  descriptor offered.
- `push_ready`  out  1  FIFO can accept a descriptor.
- `push_addr`  in  AXI_ADDR_W  start byte address (any alignment).
- `push_len`  in  LEN_W  byte count.
- `push_rnw`  in  1  1 = read from memory, 0 = write to memory.
- `dma_addr`  out  AXI_ADDR_W  to `dma_transfer.addr`.
- `dma_length`  out  LEN_W  to `dma_transfer.length`.
- `dma_rnw`  out  1  to `dma_transfer.readNotWrite`.
- `dma_start`  out  1  to `dma_transfer.start`.
- `dma_ready`  in  1  from `dma_transfer.ready`.
- `busy`  out  1  a descriptor is loaded and not yet complete.
- `level`  out  DEPTH_LOG2+1  FIFO occupancy.
- `done`  out  1  one-cycle completion pulse.
- `done_count`  out  8  completed descriptors, wraps 255→0.

## Operation
- FIFO: circular, with DEPTH_LOG2+1-bit read/write pointers. A push occurs on `push_valid & push_ready`, where `push_ready = !full`. A push is never accepted while full, including in a pop cycle. A simultaneous push and pop leaves `level` unchanged.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if the FIFO is non-empty, load the head into the `dma_addr`/`dma_length`/`dma_rnw` registers, pop, and go to ISSUE.
  - ISSUE: `dma_start = dma_ready`. If `dma_ready`, go to WAIT_BUSY; otherwise stay in ISSUE.
  - WAIT_BUSY: when `!dma_ready`, go to WAIT_DONE.
  - WAIT_DONE: when `dma_ready`, go to IDLE and set `done` for the next cycle.
- `dma_start` is combinational and asserts only in ISSUE.
- `dma_addr`, `dma_length` and `dma_rnw` change only on the IDLE load. They stay constant from ISSUE through WAIT_DONE, because `dma_transfer` uses `addr[1:0]` and `readNotWrite` combinationally for the whole transfer.
- `busy` = state ≠ IDLE.
- `done_count` increments in the same cycle `done` is high.

## Timing
- Reset values: `push_ready`=1, `dma_addr`=0, `dma_length`=0, `dma_rnw`=0, `dma_start`=0, `busy`=0, `level`=0, `done`=0, `done_count`=0; FSM in IDLE; FIFO empty.
- Push accepted in cycle 0 with an empty FIFO and the FSM in IDLE:
  - cycle 1: load and pop; `level` returns to 0.
  - cycle 2: `dma_start`=1 (if `dma_ready`).
- `done` asserts one cycle after `dma_ready` rises in WAIT_DONE. The next descriptor's load happens in that same cycle (back in IDLE), so its start follows 2 cycles after completion.
- If `dma_ready` is low on entry to ISSUE, the block waits with `dma_start`=0.
- Reset mid-transfer clears the FIFO, the FSM and the counters; `dma_transfer` shares `rst`.

## Configuration
- `DMA_SCHED_SKIP_ZERO_EN` defined: in IDLE, a head descriptor with `length`=0 is popped without being loaded or started. `done` pulses next cycle, `done_count` increments, and the FSM stays in IDLE. `dma_*` registers keep their previous values.
- Not defined: a zero-length descriptor is issued like any other.

## Test plan
- Reset, then one push (addr=0x100, len=8, rnw=1), bench `dma_transfer` model busy 10 cycles → `dma_start` high in cycle 2. `dma_addr`=0x100 and `dma_rnw`=1 held until completion. `done` pulses once; `done_count`=1.
- Push 5 descriptors back-to-back while the first is in progress → `push_ready` low when `level`=4, the 5th is accepted after the first pop, and all 5 complete in push order.
- `dma_ready` held low for 6 cycles on entry to ISSUE → `dma_start` stays 0, then a single 1-cycle `dma_start` when `dma_ready` rises.
- Push len=0 with `DMA_SCHED_SKIP_ZERO_EN` → no `dma_start`, `done` 2 cycles after the push, `done_count`+1. Without the macro → `dma_start` issued with `dma_length`=0.
- Assert `rst` during WAIT_DONE with 3 queued entries → all outputs at reset values, `level`=0, and no `done` after release.
- 256 completions → `done_count` wraps to 0.

Source files
------------

// File: rtl/dma_desc_sched.sv
// dma_desc_sched: descriptor FIFO + issue FSM driving dma_transfer; `DMA_SCHED_SKIP_ZERO_EN retires zero-length descriptors without issuing them.
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
module dma_desc_sched #(
  parameter int AXI_ADDR_W = `AXI_ADDR_W,
  parameter int LEN_W = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [AXI_ADDR_W-1:0] push_addr,
  input  logic [LEN_W-1:0]      push_len,
  input  logic                  push_rnw,
  output logic [AXI_ADDR_W-1:0] dma_addr,
  output logic [LEN_W-1:0]      dma_length,
  output logic                  dma_rnw,
  output logic                  dma_start,
  input  logic                  dma_ready,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  done,
  output logic [7:0]            done_count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state;
  logic [AXI_ADDR_W-1:0] addr_mem [DEPTH];
  logic [LEN_W-1:0] len_mem [DEPTH];
  logic [DEPTH-1:0] rnw_mem;
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
  logic full, empty, push, pop, skip;
  assign wr_idx = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_idx = rd_ptr[DEPTH_LOG2-1:0];
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {DEPTH_LOG2{1'b0}}};
  assign push_ready = !full;
  assign push = push_valid && !full;
  assign pop = state == IDLE && !empty;
  assign level = wr_ptr - rd_ptr;
  assign busy = state != IDLE;
  assign dma_start = state == ISSUE && dma_ready;
`ifdef DMA_SCHED_SKIP_ZERO_EN
  assign skip = len_mem[rd_idx] == '0;
`else
  assign skip = 1'b0;
`endif
  always_ff @(posedge clk)
    if (push) begin
      addr_mem[wr_idx] <= push_addr;
      len_mem[wr_idx] <= push_len;
      rnw_mem[wr_idx] <= push_rnw;
    end
  // dma_* registers are written only on the IDLE load so they stay stable for the whole transfer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      dma_addr <= '0;
      dma_length <= '0;
      dma_rnw <= 1'b0;
      done <= 1'b0;
      done_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      done <= 1'b0;
      case (state)
        IDLE:
          if (pop) begin
            if (skip) begin
              done <= 1'b1;
              done_count <= done_count + 1'b1;
            end else begin
              dma_addr <= addr_mem[rd_idx];
              dma_length <= len_mem[rd_idx];
              dma_rnw <= rnw_mem[rd_idx];
              state <= ISSUE;
            end
          end
        ISSUE: if (dma_ready) state <= WAIT_BUSY;
        WAIT_BUSY: if (!dma_ready) state <= WAIT_DONE;
        WAIT_DONE:
          if (dma_ready) begin
            state <= IDLE;
            done <= 1'b1;
            done_count <= done_count + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dma_desc_sched.sv
// tb_dma_desc_sched: directed tests of dma_desc_sched against a small dma_transfer ready/busy model.
module tb_dma_desc_sched;
  logic clk = 0, rst = 1;
  logic push_valid = 0, push_rnw = 0;
  logic push_ready;
  logic [31:0] push_addr = 0;
  logic [15:0] push_len = 0;
  logic [31:0] dma_addr;
  logic [15:0] dma_length;
  logic dma_rnw, dma_start, dma_ready, busy, done;
  logic [2:0] level;
  logic [7:0] done_count;
  logic model_ready, hold_low = 0;
  int busy_cnt, lat = 10;
  int checks = 0, passed = 0;
  int done_seen = 0, start_seen = 0;
  logic [31:0] start_q [$];

  dma_desc_sched #(.AXI_ADDR_W(32), .LEN_W(16), .DEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_len(push_len), .push_rnw(push_rnw),
    .dma_addr(dma_addr), .dma_length(dma_length), .dma_rnw(dma_rnw),
    .dma_start(dma_start), .dma_ready(dma_ready), .busy(busy), .level(level),
    .done(done), .done_count(done_count));

  always #5 clk = ~clk;
  assign dma_ready = model_ready && !hold_low;

  // dma_transfer stand-in: ready drops for lat cycles after each start
  always @(posedge clk or posedge rst)
    if (rst) begin
      model_ready <= 1'b1;
      busy_cnt <= 0;
    end else if (dma_start) begin
      model_ready <= 1'b0;
      busy_cnt <= lat;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) model_ready <= 1'b1;
    end

  always @(negedge clk) begin
    if (done) done_seen++;
    if (dma_start) begin
      start_seen++;
      start_q.push_back(dma_addr);
    end
  end

  task automatic push(input logic [31:0] a, input logic [15:0] l, input logic r, output int waited);
    push_addr = a; push_len = l; push_rnw = r; push_valid = 1; waited = 0;
    while (!push_ready && waited < 500) begin
      @(posedge clk); #1; waited++;
    end
    checks++;
    if (waited >= 500) $display("FAIL push_timeout: push_ready got %b need 1", push_ready);
    else passed++;
    @(posedge clk); #1;
    push_valid = 0;
  endtask

  task automatic wait_done(input int target, input int max_cycles);
    int n = 0;
    while (done_seen < target && n < max_cycles) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (done_seen < target) $display("FAIL done_timeout: done pulses got %0d need %0d", done_seen, target);
    else passed++;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({push_ready, dma_start, busy, done, dma_rnw} !== 5'b10000 || level !== 0 || done_count !== 0
        || dma_addr !== 0 || dma_length !== 0)
      $display("FAIL %s: ready/start/busy/done/rnw=%b level=%0d cnt=%0d addr=%h len=%0d need 10000 0 0 0 0",
               tag, {push_ready, dma_start, busy, done, dma_rnw}, level, done_count, dma_addr, dma_length);
    else passed++;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_values");
    rst = 0;
    @(posedge clk); #1;
    check_reset_values("after_release");
  endtask

  task automatic test_single;
    int w, base;
    bit hold_ok = 1;
    base = done_seen;
    push(32'h100, 16'd8, 1'b1, w);
    checks++;
    if (dma_start !== 0 || level !== 1) $display("FAIL single_cycle1: start=%b level=%0d need 0 1", dma_start, level);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (dma_start !== 1 || level !== 0 || busy !== 1 || dma_length !== 8)
      $display("FAIL single_start: start=%b level=%0d busy=%b len=%0d need 1 0 1 8", dma_start, level, busy, dma_length);
    else passed++;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      if (dma_addr !== 32'h100 || dma_rnw !== 1'b1) hold_ok = 0;
    end
    checks++;
    if (!hold_ok) $display("FAIL single_hold: addr/rnw changed during transfer, now %h/%b need 100/1", dma_addr, dma_rnw);
    else passed++;
    checks++;
    if (done !== 1 || done_count !== 1 || busy !== 0)
      $display("FAIL single_done: done=%b cnt=%0d busy=%b need 1 1 0", done, done_count, busy);
    else passed++;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_seen - base !== 1 || done !== 0) $display("FAIL single_pulse: pulses=%0d need 1", done_seen - base);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int w, base, qbase;
    logic [31:0] exp_addr [6] = '{32'h200, 32'h204, 32'h208, 32'h20c, 32'h210, 32'h214};
    bit order_ok = 1;
    base = done_seen;
    qbase = start_q.size();
    push(exp_addr[0], 16'd4, 1'b0, w);
    for (int i = 1; i < 5; i++) push(exp_addr[i], 16'(i * 4), 1'(i & 1), w);
    checks++;
    if (level !== 4 || push_ready !== 0) $display("FAIL b2b_full: level=%0d push_ready=%b need 4 0", level, push_ready);
    else passed++;
    push(exp_addr[5], 16'd16, 1'b1, w);
    checks++;
    if (w < 1) $display("FAIL b2b_stall: fifth push waited %0d cycles need >0", w);
    else passed++;
    wait_done(base + 6, 1000);
    for (int i = 0; i < 6; i++)
      if (start_q.size() <= qbase + i || start_q[qbase + i] !== exp_addr[i]) order_ok = 0;
    checks++;
    if (!order_ok || start_q.size() - qbase !== 6)
      $display("FAIL b2b_order: starts=%0d in order=%b need 6 1", start_q.size() - qbase, order_ok);
    else passed++;
    checks++;
    if (done_count !== 7) $display("FAIL b2b_count: done_count=%0d need 7", done_count);
    else passed++;
  endtask

  task automatic test_ready_hold;
    int w, s0;
    bit quiet = 1;
    hold_low = 1;
    push(32'h300, 16'd4, 1'b0, w);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (dma_start !== 0 || busy !== 1) quiet = 0;
    end
    checks++;
    if (!quiet) $display("FAIL hold_quiet: start=%b busy=%b need 0 1", dma_start, busy);
    else passed++;
    s0 = start_seen;
    hold_low = 0;
    #1;
    checks++;
    if (dma_start !== 1) $display("FAIL hold_release: start=%b need 1", dma_start);
    else passed++;
    wait_done(done_seen + 1, 100);
    checks++;
    if (start_seen - s0 !== 1 || done_count !== 8)
      $display("FAIL hold_single_start: starts=%0d cnt=%0d need 1 8", start_seen - s0, done_count);
    else passed++;
  endtask

  task automatic test_zero_len;
    int w;
    push(32'h400, 16'd0, 1'b1, w);
    @(posedge clk); #1;
`ifdef DMA_SCHED_SKIP_ZERO_EN
    checks++;
    if (dma_start !== 0 || done !== 1 || busy !== 0 || dma_addr !== 32'h300 || done_count !== 9)
      $display("FAIL zero_skip: start=%b done=%b busy=%b addr=%h cnt=%0d need 0 1 0 300 9",
               dma_start, done, busy, dma_addr, done_count);
    else passed++;
`else
    checks++;
    if (dma_start !== 1 || dma_length !== 0 || dma_addr !== 32'h400)
      $display("FAIL zero_issue: start=%b len=%0d addr=%h need 1 0 400", dma_start, dma_length, dma_addr);
    else passed++;
`endif
    wait_done(done_seen + 1, 100);
    checks++;
    if (done_count !== 9) $display("FAIL zero_count: done_count=%0d need 9", done_count);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int w, base;
    lat = 20;
    push(32'h500, 16'd8, 1'b0, w);
    for (int i = 0; i < 3; i++) push(32'h600 + 32'(i), 16'd2, 1'b1, w);
    checks++;
    if (level !== 3 || busy !== 1 || model_ready !== 0)
      $display("FAIL mid_setup: level=%0d busy=%b need 3 1", level, busy);
    else passed++;
    #2 rst = 1;
    #1;
    check_reset_values("mid_reset");
    @(posedge clk); #1;
    rst = 0;
    base = done_seen;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (done_seen !== base || level !== 0 || busy !== 0 || done_count !== 0)
      $display("FAIL mid_after: pulses=%0d level=%0d busy=%b cnt=%0d need 0 0 0 0",
               done_seen - base, level, busy, done_count);
    else passed++;
  endtask

  task automatic test_wrap;
    int w, base;
    lat = 2;
    base = done_seen;
    for (int i = 0; i < 256; i++) push(32'h1000 + 32'(i), 16'd1, 1'b0, w);
    wait_done(base + 256, 5000);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done_count !== 0 || done_seen - base !== 256)
      $display("FAIL wrap: done_count=%0d pulses=%0d need 0 256", done_count, done_seen - base);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_ready_hold;
    test_zero_len;
    test_reset_mid;
    test_wrap;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
